spectrum_frame_scheduler: RTL

Sequencing controller in front of the spectrum LED display. Consumes a serial stream of 64 FFT bin magnitudes per frame and max-reduces them into 8 bands. At a fixed refresh rate it applies peak-hold with decay to each band, one band per cycle. It then publishes the packed 8×12-bit result with a one-cycle `spectrum_valid` pulse for the display stage.

---
 rtl/spectrum_pkg.sv | 30 +++
 rtl/refresh_tick_gen.sv | 35 +++
 rtl/spectrum_frame_scheduler.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/spectrum_pkg.sv
// -----------------------------------------------------------------------------
// spectrum_pkg
// Shared definitions for the spectrum display path: band geometry (also used
// by the display block), the frame scheduler state encoding and the peak
// decay helper.
// -----------------------------------------------------------------------------
package spectrum_pkg;

   localparam int NUM_BANDS = 8;
   localparam int MAG_W     = 12;

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_HOLD    = 2'd1,
      ST_UPDATE  = 2'd2,
      ST_PUBLISH = 2'd3
   } state_e;

   // Proportional decay of a held peak. When the proportional step rounds to
   // zero the peak still drops by one so a band always falls to zero.
   function automatic logic [MAG_W-1:0] peak_decay(input logic [MAG_W-1:0] peak,
                                                    input int              shift);
      logic [MAG_W-1:0] step;
      step = peak >> shift;
      if (step != '0) return peak - step;
      if (peak != '0) return peak - MAG_W'(1);
      return '0;
   endfunction

endpackage

// File: rtl/refresh_tick_gen.sv
// -----------------------------------------------------------------------------
// refresh_tick_gen
// Free-running divider producing a one-cycle refresh tick every REFRESH_DIV
// clock cycles. The counter runs 0..REFRESH_DIV-1 and the tick is high while
// it sits at the terminal count.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (counter to 0)
//   tick  - refresh tick, one cycle per period
// -----------------------------------------------------------------------------
module refresh_tick_gen #(
   parameter int REFRESH_DIV = 500000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int CNT_W = $clog2(REFRESH_DIV);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick = (cnt_q == CNT_W'(REFRESH_DIV - 1));

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/spectrum_frame_scheduler.sv
// -----------------------------------------------------------------------------
// spectrum_frame_scheduler
// Collects a frame of FFT bin magnitudes, max-reduces them into NUM_BANDS
// bands, and on each refresh tick applies peak-hold with decay (one band per
// cycle) before publishing the packed band peaks with a one-cycle pulse.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   bin_valid/bin_ready  - bin stream handshake (ready only while collecting)
//   bin_idx, bin_mag     - bin index (top bits select the band), magnitude
//   bin_last             - final bin of the frame
//   spectrum_data_packed - peak array, band i at [i*MAG_W +: MAG_W]
//   spectrum_valid       - one-cycle publish pulse
//   skip_count           - saturating count of refresh ticks that were dropped
// -----------------------------------------------------------------------------
module spectrum_frame_scheduler
   import spectrum_pkg::*;
#(
   parameter int BIN_W       = 6,
   parameter int DECAY_SHIFT = 3,
   parameter int REFRESH_DIV = 500000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       bin_valid,
   output logic                       bin_ready,
   input  logic [BIN_W-1:0]           bin_idx,
   input  logic [MAG_W-1:0]           bin_mag,
   input  logic                       bin_last,
   output logic [NUM_BANDS*MAG_W-1:0] spectrum_data_packed,
   output logic                       spectrum_valid,
   output logic [7:0]                 skip_count
);

   localparam int BAND_W = $clog2(NUM_BANDS);

   state_e             state_q, state_d;
   logic [BAND_W-1:0]  b_q, b_d;
   logic [MAG_W-1:0]   acc_q  [NUM_BANDS];
   logic [MAG_W-1:0]   acc_d  [NUM_BANDS];
   logic [MAG_W-1:0]   peak_q [NUM_BANDS];
   logic [MAG_W-1:0]   peak_d [NUM_BANDS];
   logic               tick_pending_q, tick_pending_d;
   logic [7:0]         skip_count_q, skip_count_d;
   logic               spectrum_valid_q, spectrum_valid_d;

   logic               tick;
   logic               hs;
   logic               update_start;
   logic [BAND_W-1:0]  band_sel;
   logic [MAG_W-1:0]   dec;
   logic               unused_idx_bits;

   refresh_tick_gen #(
      .REFRESH_DIV(REFRESH_DIV)
   ) u_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (tick)
   );

   // Only the band-select bits of the index matter.
   assign band_sel        = bin_idx[BIN_W-1 -: BAND_W];
   assign unused_idx_bits = ^bin_idx[BIN_W-BAND_W-1:0];
   assign hs              = bin_valid & bin_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_COLLECT;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_COLLECT: if (hs && bin_last)                    state_d = ST_HOLD;
         ST_HOLD:    if (tick_pending_q)                    state_d = ST_UPDATE;
         ST_UPDATE:  if (b_q == BAND_W'(NUM_BANDS - 1))     state_d = ST_PUBLISH;
         ST_PUBLISH:                                        state_d = ST_COLLECT;
         default:                                           state_d = ST_COLLECT;
      endcase
   end

   // Output decode; the publish pulse is registered on entry to PUBLISH so it
   // lines up with the cycle the state register shows PUBLISH.
   always_comb begin
      bin_ready        = (state_q == ST_COLLECT);
      spectrum_valid_d = (state_d == ST_PUBLISH);
      update_start     = (state_q == ST_HOLD) && (state_d == ST_UPDATE);
   end

   // Datapath: band accumulation, per-band peak update, tick bookkeeping
   always_comb begin
      acc_d          = acc_q;
      peak_d         = peak_q;
      b_d            = b_q;
      dec            = '0;
      tick_pending_d = tick_pending_q;
      skip_count_d   = skip_count_q;

      if (state_q == ST_PUBLISH) begin
         for (int i = 0; i < NUM_BANDS; i++) acc_d[i] = '0;
      end else if (hs && (bin_mag > acc_q[band_sel])) begin
         acc_d[band_sel] = bin_mag;
      end

      if (state_q == ST_HOLD)        b_d = '0;
      else if (state_q == ST_UPDATE) b_d = b_q + BAND_W'(1);

      if (state_q == ST_UPDATE) begin
         dec          = peak_decay(peak_q[b_q], DECAY_SHIFT);
         peak_d[b_q]  = (acc_q[b_q] >= dec) ? acc_q[b_q] : dec;
      end

      // A tick coinciding with the consume leaves the flag set without a
      // skip: the consumed tick was the older one, the new one is kept.
      if (tick) begin
         if (tick_pending_q && !update_start && (skip_count_q != 8'hFF))
            skip_count_d = skip_count_q + 8'd1;
         tick_pending_d = 1'b1;
      end else if (update_start) begin
         tick_pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            acc_q[i]  <= '0;
            peak_q[i] <= '0;
         end
         b_q              <= '0;
         tick_pending_q   <= 1'b0;
         skip_count_q     <= '0;
         spectrum_valid_q <= 1'b0;
      end else begin
         acc_q            <= acc_d;
         peak_q           <= peak_d;
         b_q              <= b_d;
         tick_pending_q   <= tick_pending_d;
         skip_count_q     <= skip_count_d;
         spectrum_valid_q <= spectrum_valid_d;
      end
   end

   always_comb begin
      spectrum_data_packed = '0;
      for (int i = 0; i < NUM_BANDS; i++)
         spectrum_data_packed[i*MAG_W +: MAG_W] = peak_q[i];
   end

   assign spectrum_valid = spectrum_valid_q;
   assign skip_count     = skip_count_q;

endmodule
